// File: rtl/led_pkg.sv
// Shared definitions for the STP16D05 serial front-end: FSM states,
// counter-width helpers and the default chain geometry.
package led_pkg;

    // Default chain length and LED_Clk half-period, shared with the driver bench
    localparam int LED_N_DEF   = 16;
    localparam int LED_DIV_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DONE     = 3'd4
    } led_state_t;

    // Bits needed to hold the values 0..n without wrapping
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int LED_BIT_W_DEF = cnt_w(LED_N_DEF);
    localparam int LED_DIV_W_DEF = cnt_w(LED_DIV_DEF);

endpackage

// File: rtl/led_phase_tick.sv
// Phase timer: counts C_DIV system cycles from a restart and flags the
// last cycle of the phase. Saturates at the last cycle until restarted.
module led_phase_tick
    import led_pkg::*;
#(
    parameter int C_DIV = LED_DIV_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic restart,
    output logic tick
);

    localparam int              DW   = cnt_w(C_DIV);
    localparam logic [DW-1:0]   LAST = DW'(C_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Clear on phase entry, count up to the last cycle and hold there
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            div_cnt <= '0;
        else if (restart)
            div_cnt <= '0;
        else if (div_cnt != LAST)
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/led_shift_ctrl.sv
// Serial front-end for an STP16D05 driver chain. Takes a parallel pattern
// over Load/Ready, shifts it MSB-first on LED_SDI with a generated LED_Clk,
// pulses LED_LE, and collects the previous frame returning on LED_SDO.
// Every output is a flop; output values are derived from the next state so
// that each output matches the state it belongs to in the same cycle.
module led_shift_ctrl
    import led_pkg::*;
#(
    parameter int C_N   = LED_N_DEF,
    parameter int C_DIV = LED_DIV_DEF
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [C_N-1:0] Data,
    input  logic           Load,
    input  logic           Enable,
    output logic           Ready,
    output logic           Done,
    output logic [C_N-1:0] Rd_Data,
    output logic           LED_Clk,
    output logic           LED_SDI,
    output logic           LED_LE,
    output logic           LED_OE,
    input  logic           LED_SDO
);

    localparam int            BW       = cnt_w(C_N);
    localparam logic [BW-1:0] LAST_BIT = BW'(C_N - 1);

    led_state_t     state, next_state;
    logic           tick;
    logic           restart;
    logic           accept;

    logic [C_N-1:0] sh, sh_next;
    logic [C_N-1:0] rd_sh, rd_sh_next;
    logic [BW-1:0]  bit_cnt, bit_cnt_next;

    logic           ready_d, done_d, clk_d, sdi_d, le_d;

    // Ready is only ever high in IDLE/DONE, so this is the handshake
    assign accept  = Load & Ready;
    // Every state transition starts a fresh C_DIV phase
    assign restart = (next_state != state);

    led_phase_tick #(.C_DIV(C_DIV)) u_tick (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state: low/high halves of LED_Clk per bit, then latch, then done
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (accept) next_state = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick)   next_state = ST_SHIFT_HI;
            ST_SHIFT_HI: if (tick)   next_state = (bit_cnt == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
            ST_LATCH:    if (tick)   next_state = ST_DONE;
            ST_DONE:     next_state = accept ? ST_SHIFT_LO : ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Datapath next values: load, shift out at end of high phase, sample return at end of low phase
    always_comb begin
        sh_next      = sh;
        rd_sh_next   = rd_sh;
        bit_cnt_next = bit_cnt;
        if (accept) begin
            sh_next      = Data;
            bit_cnt_next = '0;
        end else if (state == ST_SHIFT_HI && tick) begin
            sh_next      = {sh[C_N-2:0], 1'b0};
            bit_cnt_next = bit_cnt + 1'b1;
        end
        if (state == ST_SHIFT_LO && tick)
            rd_sh_next = {rd_sh[C_N-2:0], LED_SDO};
    end

    // Output next values, keyed on the state being entered
    always_comb begin
        ready_d = (next_state == ST_IDLE) || (next_state == ST_DONE);
        done_d  = (next_state == ST_DONE);
        clk_d   = (next_state == ST_SHIFT_HI);
        le_d    = (next_state == ST_LATCH);
        case (next_state)
            ST_SHIFT_LO: sdi_d = sh_next[C_N-1];
            ST_SHIFT_HI: sdi_d = LED_SDI;
            default:     sdi_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sh      <= '0;
            rd_sh   <= '0;
            bit_cnt <= '0;
            Ready   <= 1'b1;
            Done    <= 1'b0;
            Rd_Data <= '0;
            LED_Clk <= 1'b0;
            LED_SDI <= 1'b0;
            LED_LE  <= 1'b0;
            LED_OE  <= 1'b1;
        end else begin
            sh      <= sh_next;
            rd_sh   <= rd_sh_next;
            bit_cnt <= bit_cnt_next;
            Ready   <= ready_d;
            Done    <= done_d;
            if (done_d)
                Rd_Data <= rd_sh_next;
            LED_Clk <= clk_d;
            LED_SDI <= sdi_d;
            LED_LE  <= le_d;
            LED_OE  <= ~Enable;
        end
    end

endmodule
